corner_locator: RTL and testbench

Consumes the per-pixel colour-match flag produced by the corner colour detector and turns it into marker positions. Per frame it accumulates the x/y sums and the hit count of matching pixels in each image quadrant. At end of frame it computes four integer centroids with a serial divider and presents them to the downstream perspective/drawing logic over a valid/ready handshake.

---
 rtl/corner_pkg.sv | 29 ++
 rtl/corner_locator_if.sv | 25 ++
 rtl/serial_divider.sv | 64 ++++++
 rtl/corner_locator.sv | 206 ++++++++++++++++++++
 tb/tb_corner_locator.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/corner_pkg.sv
// Shared types and widths for the corner locator.
// Quadrant and FSM encodings, accumulator and divider widths.
package corner_pkg;

    localparam int COORD_W    = 10;
    localparam int SUM_W      = 27;
    localparam int CNT_W      = 17;
    localparam int DIV_CYCLES = 28;
    localparam int NQ         = 4;

    typedef enum logic [1:0] {
        Q_TL,
        Q_TR,
        Q_BL,
        Q_BR
    } quad_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DIVIDE,
        S_PRESENT
    } state_e;

    function automatic quad_e quad_of(logic lower, logic right);
        return quad_e'({lower, right});
    endfunction

endpackage

// File: rtl/corner_locator_if.sv
// Pixel stream in, four corner centroids out.
// master = producer/consumer side, slave = corner_locator.
interface corner_locator_if;
    import corner_pkg::*;

    logic                     pix_valid;
    logic                     sof;
    logic                     detect;
    logic [NQ*COORD_W-1:0]    corner_x;
    logic [NQ*COORD_W-1:0]    corner_y;
    logic [NQ-1:0]            corner_found;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output pix_valid, sof, detect, out_ready,
        input  corner_x, corner_y, corner_found, out_valid
    );

    modport slave (
        input  pix_valid, sof, detect, out_ready,
        output corner_x, corner_y, corner_found, out_valid
    );

endinterface

// File: rtl/serial_divider.sv
// Restoring divider, one quotient bit per cycle.
// 1 load cycle + 27 iterations; divisor 0 gives all-ones.
module serial_divider
    import corner_pkg::*;
#(
    parameter int Q_W = COORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic [Q_W-1:0]   quotient,
    output logic             done
);

    logic [SUM_W-1:0] quo;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] dvs;
    logic [4:0]       iter;
    logic             busy;
    logic [CNT_W:0]   trial;
    logic [CNT_W-1:0] diff;
    logic             take;

    // trial subtraction of the shifted partial remainder
    always_comb begin
        trial = {rem, quo[SUM_W-1]};
        diff  = trial[CNT_W-1:0] - dvs;
        take  = trial >= {1'b0, dvs};
    end

    // load on start, then shift one bit per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            quo  <= '0;
            rem  <= '0;
            dvs  <= '0;
            iter <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quo  <= dividend;
                rem  <= '0;
                dvs  <= divisor;
                iter <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                rem  <= take ? diff : trial[CNT_W-1:0];
                quo  <= {quo[SUM_W-2:0], take};
                iter <= iter + 5'd1;
                if (iter == 5'(DIV_CYCLES - 2)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo[Q_W-1:0];

endmodule

// File: rtl/corner_locator.sv
// Per-quadrant centroid of matching pixels, one result per frame.
// CORNER_LOCATOR_DEBOUNCE_EN: hit needs detect on this and previous pixel.
module corner_locator
    import corner_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int MIN_COUNT = 16
) (
    input logic              clk,
    input logic              reset,
    corner_locator_if.slave  bus
);

    state_e               state;
    logic [COORD_W-1:0]   x_cnt, y_cnt;
    logic [COORD_W-1:0]   px, py;
    logic                 take, restart, hit, last_px;
    quad_e                pq;
    logic [NQ-1:0]        qhit;

    logic [SUM_W-1:0]     sum_x [NQ];
    logic [SUM_W-1:0]     sum_y [NQ];
    logic [CNT_W-1:0]     cnt   [NQ];

    logic [3:0]           sel;
    logic                 go;
    logic                 div_start, div_done;
    logic [SUM_W-1:0]     div_dvd;
    logic [CNT_W-1:0]     div_dvs;
    logic [COORD_W-1:0]   div_q;
    logic [COORD_W-1:0]   quo_r   [2*NQ];
    logic [COORD_W-1:0]   quo_fin [2*NQ];

    logic [NQ*COORD_W-1:0] nx, ny, cx, cy;
    logic [NQ-1:0]         nf, cf;
    logic                  ov;

`ifdef CORNER_LOCATOR_DEBOUNCE_EN
    logic prev_det;

    // remember detect of the previous valid pixel
    always_ff @(posedge clk) begin
        if (reset)
            prev_det <= 1'b0;
        else if (bus.pix_valid)
            prev_det <= bus.detect;
    end
`endif

    // current pixel position, hit qualification and quadrant
    always_comb begin
        px      = bus.sof ? '0 : x_cnt;
        py      = bus.sof ? '0 : y_cnt;
        take    = bus.pix_valid &&
                  ((state == S_ACCUM) ||
                   (state == S_IDLE && bus.sof));
        restart = take && bus.sof;
`ifdef CORNER_LOCATOR_DEBOUNCE_EN
        hit     = take && bus.detect && prev_det &&
                  (px != '0);
`else
        hit     = take && bus.detect;
`endif
        pq      = quad_of(py >= COORD_W'(V_ACTIVE / 2),
                          px >= COORD_W'(H_ACTIVE / 2));
        qhit    = hit ? (NQ'(1) << pq) : '0;
        last_px = (px == COORD_W'(H_ACTIVE - 1)) &&
                  (py == COORD_W'(V_ACTIVE - 1));
    end

    // raster position, advanced by every valid pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (bus.pix_valid) begin
            if (px == COORD_W'(H_ACTIVE - 1)) begin
                x_cnt <= '0;
                y_cnt <= (py == COORD_W'(V_ACTIVE - 1)) ?
                         '0 : py + 1'b1;
            end else begin
                x_cnt <= px + 1'b1;
                y_cnt <= py;
            end
        end
    end

    // quadrant sums and counts; sof restarts from this pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int q = 0; q < NQ; q++) begin
                sum_x[q] <= '0;
                sum_y[q] <= '0;
                cnt[q]   <= '0;
            end
        end else if (restart) begin
            for (int q = 0; q < NQ; q++) begin
                sum_x[q] <= qhit[q] ? SUM_W'(px) : '0;
                sum_y[q] <= qhit[q] ? SUM_W'(py) : '0;
                cnt[q]   <= qhit[q] ? CNT_W'(1) : '0;
            end
        end else begin
            for (int q = 0; q < NQ; q++) begin
                if (qhit[q]) begin
                    sum_x[q] <= sum_x[q] + SUM_W'(px);
                    sum_y[q] <= sum_y[q] + SUM_W'(py);
                    cnt[q]   <= cnt[q] + 1'b1;
                end
            end
        end
    end

    // division sequencing: sel is the next division to load
    always_comb begin
        div_start = go || (div_done && sel != 4'd8);
        div_dvd   = sel[0] ? sum_y[sel[2:1]] : sum_x[sel[2:1]];
        div_dvs   = cnt[sel[2:1]];
    end

    serial_divider #(
        .Q_W (COORD_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (div_dvd),
        .divisor  (div_dvs),
        .quotient (div_q),
        .done     (div_done)
    );

    // final coordinates with the not-found quadrants zeroed
    always_comb begin
        for (int i = 0; i < 2 * NQ; i++) begin
            quo_fin[i] = (div_done && sel == 4'(i + 1)) ?
                         div_q : quo_r[i];
        end
        nx = '0;
        ny = '0;
        nf = '0;
        for (int q = 0; q < NQ; q++) begin
            nf[q] = cnt[q] >= CNT_W'(MIN_COUNT);
            if (nf[q]) begin
                nx[q*COORD_W +: COORD_W] = quo_fin[2*q];
                ny[q*COORD_W +: COORD_W] = quo_fin[2*q+1];
            end
        end
    end

    // frame FSM with registered result and handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            sel   <= '0;
            go    <= 1'b0;
            ov    <= 1'b0;
            cx    <= '0;
            cy    <= '0;
            cf    <= '0;
            for (int i = 0; i < 2 * NQ; i++)
                quo_r[i] <= '0;
        end else begin
            go <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (take)
                        state <= S_ACCUM;
                end
                S_ACCUM: begin
                    if (take && last_px) begin
                        state <= S_DIVIDE;
                        sel   <= '0;
                        go    <= 1'b1;
                    end
                end
                S_DIVIDE: begin
                    if (div_start)
                        sel <= sel + 4'd1;
                    if (div_done) begin
                        quo_r[3'(sel - 4'd1)] <= div_q;
                        if (sel == 4'd8) begin
                            state <= S_PRESENT;
                            ov    <= 1'b1;
                            cx    <= nx;
                            cy    <= ny;
                            cf    <= nf;
                        end
                    end
                end
                S_PRESENT: begin
                    if (bus.out_ready) begin
                        state <= S_IDLE;
                        ov    <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.out_valid    = ov;
    assign bus.corner_x     = cx;
    assign bus.corner_y     = cy;
    assign bus.corner_found = cf;

endmodule

// File: tb/tb_corner_locator.sv
// Randomised frames against a per-frame centroid model.
// Runs reduced 64x48 frames; honours CORNER_LOCATOR_DEBOUNCE_EN.
module tb_corner_locator;

    localparam int H    = 64;
    localparam int V    = 48;
    localparam int MINC = 16;
    localparam int LAT  = 225;

    typedef struct packed {
        logic [3:0]  f;
        logic [39:0] x;
        logic [39:0] y;
    } res_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    corner_locator_if bus ();

    corner_locator #(
        .H_ACTIVE  (H),
        .V_ACTIVE  (V),
        .MIN_COUNT (MINC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    bit   det [V][H];
    int   n_tests = 0;
    int   n_fail  = 0;
    res_t exp_cur  = '0;
    res_t exp_pend = '0;
    bit   chk_en   = 1'b0;
    logic ov_prev  = 1'b0;
    logic rdy_prev = 1'b0;

    task automatic check(input string name,
                         input logic [127:0] act,
                         input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h",
                     name, act, req);
        end
    endtask

    function automatic res_t dut_res();
        res_t r;
        r.f = bus.corner_found;
        r.x = bus.corner_x;
        r.y = bus.corner_y;
        return r;
    endfunction

    function automatic logic [39:0] p4(int a, int b,
                                       int c, int d);
        return {10'(d), 10'(c), 10'(b), 10'(a)};
    endfunction

    // centroid of every hit pixel in each quadrant
    function automatic res_t model();
        res_t   r;
        longint sx [4];
        longint sy [4];
        longint cn [4];
        int     q;
        bit     h;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            sx[i] = 0;
            sy[i] = 0;
            cn[i] = 0;
        end
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                h = det[y][x];
`ifdef CORNER_LOCATOR_DEBOUNCE_EN
                h = h && ((x > 0) ? det[y][x-1] : 1'b0);
`endif
                q = ((y >= V / 2) ? 2 : 0) +
                    ((x >= H / 2) ? 1 : 0);
                if (h) begin
                    sx[q] += x;
                    sy[q] += y;
                    cn[q] += 1;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (cn[i] >= MINC) begin
                r.f[i] = 1'b1;
                r.x[i*10 +: 10] = 10'(sx[i] / cn[i]);
                r.y[i*10 +: 10] = 10'(sy[i] / cn[i]);
            end
        end
        return r;
    endfunction

    task automatic clear_det();
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                det[y][x] = 1'b0;
    endtask

    task automatic blk(int x0, int y0, int w, int h);
        for (int y = y0; y < y0 + h; y++)
            for (int x = x0; x < x0 + w; x++)
                det[y][x] = 1'b1;
    endtask

    task automatic rand_fill();
        int dens [4];
        int pick [4] = '{0, 1, 5, 30};
        int q;
        for (int i = 0; i < 4; i++)
            dens[i] = pick[$urandom_range(0, 3)];
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                q = ((y >= V / 2) ? 2 : 0) +
                    ((x >= H / 2) ? 1 : 0);
                det[y][x] = ($urandom_range(0, 99) < dens[q]);
            end
        end
        blk($urandom_range(0, 26), $urandom_range(0, 18), 5, 5);
    endtask

    task automatic drive_px(input bit s, input bit d);
        if ($urandom_range(0, 15) == 0) begin
            bus.pix_valid = 1'b0;
            bus.sof       = 1'($urandom_range(0, 1));
            bus.detect    = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        bus.pix_valid = 1'b1;
        bus.sof       = s;
        bus.detect    = d;
        @(posedge clk);
        #1;
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.detect    = 1'b0;
    endtask

    task automatic stream();
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                drive_px(x == 0 && y == 0, det[y][x]);
    endtask

    task automatic wait_result(input bit junk);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < 400) begin
            if (junk) begin
                bus.pix_valid = 1'($urandom_range(0, 1));
                bus.sof       = 1'($urandom_range(0, 1));
                bus.detect    = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            n++;
        end
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.detect    = 1'b0;
        check("latency", n, LAT);
    endtask

    task automatic frame(input bit junk, input int pre);
        exp_pend = model();
        for (int i = 0; i < pre; i++)
            drive_px(i == 0, (i % H) < H / 2);
        stream();
        wait_result(junk);
    endtask

    task automatic handshake();
        repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("handshake_clear", bus.out_valid, 1'b0);
    endtask

    task automatic do_reset();
        chk_en        = 1'b0;
        reset         = 1'b1;
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.detect    = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("reset_valid", bus.out_valid, 1'b0);
        check("reset_outputs", dut_res(), '0);
        reset    = 1'b0;
        exp_cur  = '0;
        ov_prev  = 1'b0;
        rdy_prev = 1'b0;
        chk_en   = 1'b1;
    endtask

    // result registers must match the model while valid and just after
    always @(negedge clk) begin
        if (chk_en) begin
            if (bus.out_valid === 1'b1 && ov_prev !== 1'b1)
                exp_cur = exp_pend;
            if (bus.out_valid === 1'b1 || ov_prev === 1'b1)
                check("outputs", dut_res(), exp_cur);
            if (ov_prev === 1'b1 && rdy_prev !== 1'b1)
                check("valid_hold", bus.out_valid, 1'b1);
            ov_prev  = bus.out_valid;
            rdy_prev = bus.out_ready;
        end
    end

    res_t want;

    initial begin
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.detect    = 1'b0;
        bus.out_ready = 1'b0;
        do_reset();

        clear_det();
        frame(1'b0, 0);
        check("blank_model", exp_pend, '0);
        check("blank_dut", dut_res(), '0);
        handshake();

        clear_det();
        blk(10, 2, 4, 4);
        blk(50, 4, 4, 4);
        blk(5, 30, 4, 4);
        blk(58, 42, 4, 4);
        frame(1'b1, 0);
`ifdef CORNER_LOCATOR_DEBOUNCE_EN
        want = '0;
`else
        want = {4'hF, p4(11, 51, 6, 59), p4(3, 5, 31, 43)};
`endif
        check("blocks_model", exp_pend, want);
        check("blocks_dut", dut_res(), want);
        handshake();

        det[2][10] = 1'b0;
        frame(1'b0, 0);
`ifdef CORNER_LOCATOR_DEBOUNCE_EN
        want = '0;
`else
        want = {4'hE, p4(0, 51, 6, 59), p4(0, 5, 31, 43)};
`endif
        check("minus1_model", exp_pend, want);
        check("minus1_dut", dut_res(), want);
        handshake();

        clear_det();
        for (int y = 2; y <= 10; y++)
            for (int x = 2; x <= 20; x += 2)
                det[y][x] = 1'b1;
        frame(1'b0, 0);
`ifdef CORNER_LOCATOR_DEBOUNCE_EN
        want = '0;
`else
        want = {4'h1, p4(11, 0, 0, 0), p4(6, 0, 0, 0)};
`endif
        check("isolated_model", exp_pend, want);
        check("isolated_dut", dut_res(), want);
        handshake();

        clear_det();
        for (int y = 8; y <= 23; y++) begin
            det[y][10] = 1'b1;
            det[y][11] = 1'b1;
        end
        frame(1'b1, 0);
`ifdef CORNER_LOCATOR_DEBOUNCE_EN
        want = {4'h1, p4(11, 0, 0, 0), p4(15, 0, 0, 0)};
`else
        want = {4'h1, p4(10, 0, 0, 0), p4(15, 0, 0, 0)};
`endif
        check("runs_model", exp_pend, want);
        check("runs_dut", dut_res(), want);
        handshake();

        for (int k = 0; k < 3; k++) begin
            rand_fill();
            frame(1'b1, 0);
            handshake();
        end

        rand_fill();
        frame(1'b0, 0);
        for (int i = 0; i < 500; i++)
            drive_px(i == 0, 1'($urandom_range(0, 1)));
        check("bp_valid", bus.out_valid, 1'b1);
        check("bp_hold", dut_res(), exp_pend);
        handshake();
        rand_fill();
        frame(1'b0, 0);
        handshake();

        rand_fill();
        frame(1'b1, 1000);
        handshake();

        rand_fill();
        exp_pend = model();
        stream();
        repeat (100) begin
            @(posedge clk);
            #1;
        end
        do_reset();
        rand_fill();
        frame(1'b0, 0);
        handshake();

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule
